// File: rtl/strait_bist_array.sv
// strait_bist_array: ROWS x COLS output-stationary MAC array. Each row's P
// registers form a scan chain. An on-chip BIST sequencer shifts LFSR stimulus
// through the chains, captures MAC results and compacts them in a MISR.
// Optional feature macro: STRAIT_FAULT_INJ_EN adds a stuck-at-1 injector on
// one P bit of one PE.
//
// BIST handshake: with mode=1, a one-cycle bist_start pulse is accepted only
// in IDLE or DONE. bist_busy then stays high until the verdict is formed.
// bist_done then holds, with bist_pass valid, until mode drops or a new start
// arrives. A start pulse while busy is ignored. Dropping mode while busy
// aborts the run.
module strait_bist_array #(
  parameter int          ROWS         = 8,
  parameter int          COLS         = 8,
  parameter int          DATA_WIDTH   = 16,
  parameter int          ACC_WIDTH    = 32,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         scan_en,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_A,
  input  logic [COLS*DATA_WIDTH-1:0]   in_W,
  input  logic [ROWS*ACC_WIDTH-1:0]    scan_in_p,
  output logic [ROWS*ACC_WIDTH-1:0]    scan_out_p,
  input  logic                         bist_start,
  input  logic [31:0]                  golden_sig,
  output logic                         bist_busy,
  output logic                         bist_done,
  output logic                         bist_pass,
  output logic [31:0]                  signature
`ifdef STRAIT_FAULT_INJ_EN
  ,
  input  logic                         inj_en,
  input  logic [$clog2(ROWS)-1:0]      inj_row,
  input  logic [$clog2(COLS)-1:0]      inj_col,
  input  logic [$clog2(ACC_WIDTH)-1:0] inj_bit
`endif
);

  localparam int          CW   = $clog2(COLS + 1);
  localparam int          PW   = $clog2(NUM_PATTERNS + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1, Galois form

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CAPTURE, S_FLUSH, S_COMPARE, S_DONE
  } state_t;

  state_t          state;
  logic [31:0]     lfsr, lfsr_next;
  logic [31:0]     misr, misr_next, fold;
  logic [PW-1:0]   pat_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic            busy, done, pass;

  logic            ext, en;
  logic [DATA_WIDTH-1:0] l_a, l_w;
  logic [DATA_WIDTH-1:0] a_src [ROWS];
  logic [DATA_WIDTH-1:0] w_src [COLS];
  logic [ACC_WIDTH-1:0]  p_src [ROWS];

  logic [DATA_WIDTH-1:0] a_q   [ROWS][COLS];
  logic [DATA_WIDTH-1:0] w_q   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  p_q   [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_in  [ROWS][COLS];
  logic [DATA_WIDTH-1:0] w_in  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  p_in  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  p_nxt [ROWS][COLS];

  // LFSR-derived operand bases; wide operands take the zero-extended LFSR.
  assign l_a = DATA_WIDTH'(lfsr);
  if (DATA_WIDTH <= 32) begin : g_w_narrow
    assign l_w = lfsr[31 -: DATA_WIDTH];
  end else begin : g_w_wide
    assign l_w = DATA_WIDTH'(lfsr);
  end

  // Source mux: external ports in functional mode or IDLE, otherwise the BIST.
  always_comb begin
    ext = !mode || (state == S_IDLE);
    en  = ext ? scan_en : (state != S_CAPTURE);
    for (int r = 0; r < ROWS; r++) begin
      a_src[r] = ext ? in_A[r*DATA_WIDTH +: DATA_WIDTH] : (l_a ^ DATA_WIDTH'(r));
      p_src[r] = ext ? scan_in_p[r*ACC_WIDTH +: ACC_WIDTH]
                     : (lfsr[ACC_WIDTH-1:0] ^ ACC_WIDTH'(r));
    end
    for (int c = 0; c < COLS; c++) begin
      w_src[c] = ext ? in_W[c*DATA_WIDTH +: DATA_WIDTH] : (l_w ^ DATA_WIDTH'(c));
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [2*DATA_WIDTH-1:0] prod;
      logic [ACC_WIDTH-1:0]    p_calc;

      if (c == 0) begin : g_head
        assign a_in[r][c] = a_src[r];
        assign p_in[r][c] = p_src[r];
      end else begin : g_link
        assign a_in[r][c] = a_q[r][c-1];
        assign p_in[r][c] = p_q[r][c-1];
      end
      if (r == 0) begin : g_top
        assign w_in[r][c] = w_src[c];
      end else begin : g_down
        assign w_in[r][c] = w_q[r-1][c];
      end

      assign prod = a_in[r][c] * w_in[r][c];

      // Next P: shift when enabled, else accumulate the wrapped product.
      always_comb begin
        p_calc = en ? p_in[r][c] : (p_in[r][c] + ACC_WIDTH'(prod));
`ifdef STRAIT_FAULT_INJ_EN
        if (inj_en && (int'(inj_row) == r) && (int'(inj_col) == c) &&
            (int'(inj_bit) < ACC_WIDTH))
          p_calc[inj_bit] = 1'b1;
`endif
      end
      assign p_nxt[r][c] = p_calc;
    end
    assign scan_out_p[r*ACC_WIDTH +: ACC_WIDTH] = p_q[r][COLS-1];
  end

  // PE register file: operand pipelines and accumulators.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!rst) begin
          a_q[r][c] <= '0;
          w_q[r][c] <= '0;
          p_q[r][c] <= '0;
        end else begin
          a_q[r][c] <= a_in[r][c];
          w_q[r][c] <= w_in[r][c];
          p_q[r][c] <= p_nxt[r][c];
        end
      end
    end
  end

  // Compaction input: XOR of every row's chain tail.
  always_comb begin
    fold = '0;
    for (int r = 0; r < ROWS; r++) fold = fold ^ 32'(p_q[r][COLS-1]);
  end

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign misr_next = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ fold;

  // BIST sequencer with registered busy/done/pass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      misr    <= '0;
      pat_cnt <= '0;
      cyc_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (mode && bist_start) begin
            state   <= S_SHIFT;
            lfsr    <= LFSR_SEED;
            misr    <= '0;
            pat_cnt <= '0;
            cyc_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end else if (!mode) begin
            state <= S_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: begin
          if (!mode) begin
            // Abort: array contents are left as they are.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            lfsr <= lfsr_next;
            case (state)
              S_SHIFT: begin
                // The first pattern has nothing captured to shift out yet.
                if (pat_cnt != '0) misr <= misr_next;
                if (cyc_cnt == CW'(COLS - 1)) begin
                  cyc_cnt <= '0;
                  state   <= S_CAPTURE;
                end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
                end
              end
              S_CAPTURE: begin
                pat_cnt <= pat_cnt + 1'b1;
                state   <= (pat_cnt == PW'(NUM_PATTERNS - 1)) ? S_FLUSH : S_SHIFT;
              end
              S_FLUSH: begin
                misr <= misr_next;
                if (cyc_cnt == CW'(COLS - 1)) begin
                  cyc_cnt <= '0;
                  state   <= S_COMPARE;
                end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
                end
              end
              S_COMPARE: begin
                pass  <= (misr == golden_sig);
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bist_busy = busy;
  assign bist_done = done;
  assign bist_pass = pass;
  assign signature = misr;

endmodule

// File: tb/tb_strait_bist_array.sv
// tb_strait_bist_array: directed checks of strait_bist_array with a 2x2 array,
// 8-bit operands, 16-bit accumulators and 4 BIST patterns. The golden
// signature comes from a small array/LFSR/MISR model in this file.
module tb_strait_bist_array;

  localparam int          ROWS = 2;
  localparam int          COLS = 2;
  localparam int          DW   = 8;
  localparam int          AW   = 16;
  localparam int          NP   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          RUN_CYCLES = NP * (COLS + 1) + COLS + 1;  // 15

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 mode = 1'b0;
  logic                 scan_en = 1'b0;
  logic [ROWS*DW-1:0]   in_A = '0;
  logic [COLS*DW-1:0]   in_W = '0;
  logic [ROWS*AW-1:0]   scan_in_p = '0;
  logic [ROWS*AW-1:0]   scan_out_p;
  logic                 bist_start = 1'b0;
  logic [31:0]          golden_sig = '0;
  logic                 bist_busy, bist_done, bist_pass;
  logic [31:0]          signature;
`ifdef STRAIT_FAULT_INJ_EN
  logic                 inj_en = 1'b0;
  logic [0:0]           inj_row = '0;
  logic [0:0]           inj_col = '0;
  logic [3:0]           inj_bit = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_golden;

  strait_bist_array #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
    .NUM_PATTERNS(NP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .scan_en(scan_en),
    .in_A(in_A), .in_W(in_W), .scan_in_p(scan_in_p), .scan_out_p(scan_out_p),
    .bist_start(bist_start), .golden_sig(golden_sig),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
    .signature(signature)
`ifdef STRAIT_FAULT_INJ_EN
    , .inj_en(inj_en), .inj_row(inj_row), .inj_col(inj_col), .inj_bit(inj_bit)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_a [ROWS][COLS];
  logic [DW-1:0] m_w [ROWS][COLS];
  logic [AW-1:0] m_p [ROWS][COLS];

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [31:0] misr_adv(input logic [31:0] m, input logic [31:0] f);
    return {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ f;
  endfunction

  function automatic logic [31:0] m_fold();
    logic [31:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f = f ^ {16'h0, m_p[r][COLS-1]};
    return f;
  endfunction

  // One clock edge of the array, updated in place from the far corner back.
  function automatic void m_edge(input logic [31:0] l, input bit en);
    logic [DW-1:0] ain, win;
    logic [AW-1:0] pin;
    for (int r = ROWS - 1; r >= 0; r--) begin
      for (int c = COLS - 1; c >= 0; c--) begin
        if (c == 0) begin
          ain = l[7:0] ^ 8'(r);
          pin = l[15:0] ^ 16'(r);
        end else begin
          ain = m_a[r][c-1];
          pin = m_p[r][c-1];
        end
        if (r == 0) win = l[31:24] ^ 8'(c);
        else        win = m_w[r-1][c];
        m_a[r][c] = ain;
        m_w[r][c] = win;
        m_p[r][c] = en ? pin : pin + ({8'h00, ain} * {8'h00, win});
      end
    end
  endfunction

  function automatic logic [31:0] model_sig();
    logic [31:0] l, m;
    l = SEED;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        m_a[r][c] = '0; m_w[r][c] = '0; m_p[r][c] = '0;
      end
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < COLS; s++) begin
        if (p > 0) m = misr_adv(m, m_fold());
        m_edge(l, 1'b1);
        l = lfsr_adv(l);
      end
      m_edge(l, 1'b0);
      l = lfsr_adv(l);
    end
    for (int s = 0; s < COLS; s++) begin
      m = misr_adv(m, m_fold());
      m_edge(l, 1'b1);
      l = lfsr_adv(l);
    end
    return m;
  endfunction

  // ---------------- driver and check tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles, input bit rand_in);
    rst = 1'b0;
    repeat (cycles) begin
      if (rand_in) begin
        mode       = 1'($urandom_range(1, 0));
        scan_en    = 1'($urandom_range(1, 0));
        bist_start = 1'($urandom_range(1, 0));
        in_A       = 16'($urandom_range(16'hFFFF, 0));
        in_W       = 16'($urandom_range(16'hFFFF, 0));
        scan_in_p  = $urandom();
        golden_sig = $urandom();
      end
      step();
    end
    rst        = 1'b1;
    mode       = 1'b0;
    scan_en    = 1'b0;
    bist_start = 1'b0;
    in_A       = '0;
    in_W       = '0;
    scan_in_p  = '0;
  endtask

  // Launch a run and wait for bist_done; stray_at >= 0 pulses start mid-run.
  task automatic run_bist(input string tag, input logic [31:0] gsig,
                          input int stray_at, input logic exp_pass);
    int   n;
    logic busy_last;
    golden_sig = gsig;
    mode       = 1'b1;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    check({tag, "_busy_at_start"}, 32'(bist_busy), 32'd1);
    n = 0;
    busy_last = 1'b0;
    while (!bist_done && n < 200) begin
      busy_last  = bist_busy;
      bist_start = (n == stray_at);
      step();
      n++;
    end
    bist_start = 1'b0;
    check({tag, "_done_latency"}, 32'(n), 32'(RUN_CYCLES));
    check({tag, "_busy_before_done"}, 32'(busy_last), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bist_busy), 32'd0);
    check({tag, "_pass"}, 32'(bist_pass), 32'(exp_pass));
    check({tag, "_signature"}, signature, model_golden);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_golden = model_sig();

    // Reset with random inputs
    do_reset(3, 1'b1);
    check("rst_scan_out", scan_out_p, 32'h0);
    check("rst_busy", 32'(bist_busy), 32'd0);
    check("rst_done", 32'(bist_done), 32'd0);
    check("rst_pass", 32'(bist_pass), 32'd0);
    check("rst_signature", signature, 32'h0);

    // Functional MAC: row0 A=3, W=4/5 -> 3*4 + 3*5 = 27 at the row0 tail
    in_A = {8'd0, 8'd3};
    in_W = {8'd5, 8'd4};
    step();
    check("mac_c1_row0", 32'(scan_out_p[15:0]), 32'd0);
    step();
    check("mac_c2_row0", 32'(scan_out_p[15:0]), 32'd27);
    step();
    check("mac_c3_row0", 32'(scan_out_p[15:0]), 32'd27);
    check("mac_c3_row1", 32'(scan_out_p[31:16]), 32'd0);

    // Accumulator wrap: 255*255*2 = 130050 -> mod 2^16 = 64514
    do_reset(1, 1'b0);
    in_A = {8'd0, 8'd255};
    in_W = {8'd255, 8'd255};
    step();
    step();
    check("mac_wrap_row0", 32'(scan_out_p[15:0]), 32'd64514);

    // Scan shift: BEEF into row1 head reaches the tail two edges later
    do_reset(1, 1'b0);
    scan_en   = 1'b1;
    scan_in_p = {16'hBEEF, 16'h0000};
    step();
    scan_in_p = '0;
    check("scan_e1_row1", 32'(scan_out_p[31:16]), 32'h0);
    step();
    check("scan_e2_row1", 32'(scan_out_p[31:16]), 32'hBEEF);
    check("scan_e2_row0", 32'(scan_out_p[15:0]), 32'h0);
    step();
    check("scan_e3_row1", 32'(scan_out_p[31:16]), 32'h0);
    scan_en = 1'b0;

    // BIST pass run
    run_bist("bist_pass", model_golden, -1, 1'b1);
    step();
    check("done_hold", 32'(bist_done), 32'd1);
    check("pass_hold", 32'(bist_pass), 32'd1);

    // Restart from DONE with a wrong golden value and a stray start mid-run
    run_bist("bist_fail", model_golden ^ 32'h1, 3, 1'b0);

    // Leaving DONE when mode drops
    mode = 1'b0;
    step();
    check("done_exit_done", 32'(bist_done), 32'd0);
    check("done_exit_pass", 32'(bist_pass), 32'd0);

    // Abort: drop mode after five edges of a run
    mode       = 1'b1;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (4) step();
    check("abort_busy_before", 32'(bist_busy), 32'd1);
    mode = 1'b0;
    step();
    check("abort_busy", 32'(bist_busy), 32'd0);
    check("abort_done", 32'(bist_done), 32'd0);

    // Reset in the middle of a run
    mode       = 1'b1;
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (8) step();
    do_reset(1, 1'b0);
    check("midrst_busy", 32'(bist_busy), 32'd0);
    check("midrst_signature", signature, 32'h0);
    check("midrst_scan_out", scan_out_p, 32'h0);

    // A fresh run after abort and reset reproduces the golden signature
    run_bist("bist_rerun", model_golden, -1, 1'b1);

`ifdef STRAIT_FAULT_INJ_EN
    // Stuck-at-1 on bit 3 of PE(1,0) corrupts the signature
    mode = 1'b0;
    step();
    inj_en  = 1'b1;
    inj_row = 1'b1;
    inj_col = 1'b0;
    inj_bit = 4'd3;
    begin
      int n;
      golden_sig = model_golden;
      mode       = 1'b1;
      bist_start = 1'b1;
      step();
      bist_start = 1'b0;
      n = 0;
      while (!bist_done && n < 200) begin
        step();
        n++;
      end
      check("inj_done_latency", 32'(n), 32'(RUN_CYCLES));
      check("inj_pass", 32'(bist_pass), 32'd0);
    end
    inj_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
